// File: rtl/jogo_memoria_param.sv
// Memory game: fills a sequence from a free-running LFSR, shows it on the LEDs,
// then compares each player press against it. Supports full and growing modes.
module jogo_memoria_param #(
    parameter int unsigned  NBOT    = 4,
    parameter int unsigned  DEPTH   = 16,
    parameter int unsigned  SHOW_T  = 500,
    parameter int unsigned  TMR_LIM = 5000,
    localparam int unsigned IW      = (NBOT > 1) ? $clog2(NBOT) : 1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            jogar,
    input  logic            modo,
    input  logic [NBOT-1:0] botoes,
    output logic [NBOT-1:0] leds,
    output logic            ganhou,
    output logic            perdeu,
    output logic            pronto,
    output logic            db_timeout,
    output logic [3:0]      db_estado,
    output logic [AW-1:0]   db_rodada,
    output logic [AW-1:0]   db_endereco,
    output logic [NBOT-1:0] db_memoria,
    output logic [NBOT-1:0] db_jogada
);

    localparam int unsigned   TMAX     = (SHOW_T > TMR_LIM) ? SHOW_T : TMR_LIM;
    localparam int unsigned   TW       = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SHOW_END = TW'(SHOW_T - 1);
    localparam logic [TW-1:0] TMR_END  = TW'(TMR_LIM - 1);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        GERA        = 4'h1,
        MOSTRA_ON   = 4'h2,
        MOSTRA_OFF  = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROX_JOGADA = 4'h7,
        PROX_RODADA = 4'h8,
        ACERTOU     = 4'hA,
        ERROU       = 4'hE
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [NBOT-1:0] botoes_prev;
    logic            modo_r;
    logic [AW-1:0]   endereco;
    logic [AW-1:0]   rodada;
    logic [TW-1:0]   tmr;
    logic [IW-1:0]   mem [DEPTH];

    logic            lfsr_fb_c;
    logic            press_c;
    logic            hit_c;
    logic [NBOT-1:0] atual_c;
    logic [NBOT-1:0] prox_c;
    logic [NBOT-1:0] first_c;

    function automatic logic [NBOT-1:0] onehot(input logic [IW-1:0] v);
        return NBOT'(1) << v;
    endfunction

    assign lfsr_fb_c   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign atual_c     = onehot(mem[endereco]);
    assign prox_c      = onehot(mem[endereco + AW'(1)]);
    assign first_c     = onehot(mem[0]);
    // A press is a rising edge from all-released to anything pressed.
    assign press_c     = (botoes != '0) && (botoes_prev == '0);
    assign hit_c       = (db_jogada == atual_c);

    assign db_estado   = state;
    assign db_rodada   = rodada;
    assign db_endereco = endereco;

    // Sequence storage; contents are don't-care across reset.
    always_ff @(posedge clock) begin
        if (state == GERA) begin
            mem[endereco] <= lfsr[IW-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= INICIAL;
            lfsr        <= 16'hACE1;
            botoes_prev <= '0;
            modo_r      <= 1'b0;
            endereco    <= '0;
            rodada      <= '0;
            tmr         <= '0;
            leds        <= '0;
            ganhou      <= 1'b0;
            perdeu      <= 1'b0;
            pronto      <= 1'b0;
            db_timeout  <= 1'b0;
            db_memoria  <= '0;
            db_jogada   <= '0;
        end else begin
            lfsr        <= {lfsr[14:0], lfsr_fb_c};
            botoes_prev <= botoes;
            db_memoria  <= (state == INICIAL) ? '0 : atual_c;

            case (state)
                INICIAL, ACERTOU, ERROU: begin
                    leds <= '0;
                    if (jogar) begin
                        state      <= GERA;
                        modo_r     <= modo;
                        endereco   <= '0;
                        tmr        <= '0;
                        ganhou     <= 1'b0;
                        perdeu     <= 1'b0;
                        pronto     <= 1'b0;
                        db_timeout <= 1'b0;
                        db_jogada  <= '0;
                    end
                end

                // One entry per cycle; endereco doubles as the write index.
                GERA: begin
                    if (endereco == LAST) begin
                        rodada   <= modo_r ? '0 : LAST;
                        endereco <= '0;
                        tmr      <= '0;
                        leds     <= first_c;
                        state    <= MOSTRA_ON;
                    end else begin
                        endereco <= endereco + AW'(1);
                    end
                end

                MOSTRA_ON: begin
                    if (tmr == SHOW_END) begin
                        tmr   <= '0;
                        leds  <= '0;
                        state <= MOSTRA_OFF;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                MOSTRA_OFF: begin
                    if (tmr == SHOW_END) begin
                        tmr <= '0;
                        if (endereco < rodada) begin
                            endereco <= endereco + AW'(1);
                            leds     <= prox_c;
                            state    <= MOSTRA_ON;
                        end else begin
                            endereco <= '0;
                            state    <= ESPERA;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                // A press on the final timer cycle beats the timeout.
                ESPERA: begin
                    if (press_c) begin
                        state <= REGISTRA;
                    end else if (tmr == TMR_END) begin
                        perdeu     <= 1'b1;
                        pronto     <= 1'b1;
                        db_timeout <= 1'b1;
                        state      <= ERROU;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end

                REGISTRA: begin
                    db_jogada <= botoes;
                    state     <= COMPARA;
                end

                COMPARA: begin
                    if (!hit_c) begin
                        perdeu <= 1'b1;
                        pronto <= 1'b1;
                        state  <= ERROU;
                    end else if (endereco < rodada) begin
                        state <= PROX_JOGADA;
                    end else if (rodada == LAST) begin
                        ganhou <= 1'b1;
                        pronto <= 1'b1;
                        state  <= ACERTOU;
                    end else begin
                        state <= PROX_RODADA;
                    end
                end

                PROX_JOGADA: begin
                    endereco <= endereco + AW'(1);
                    tmr      <= '0;
                    state    <= ESPERA;
                end

                PROX_RODADA: begin
                    rodada   <= rodada + AW'(1);
                    endereco <= '0;
                    tmr      <= '0;
                    leds     <= first_c;
                    state    <= MOSTRA_ON;
                end

                default: begin
                    leds  <= '0;
                    state <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: cycle-exact directed/random games checked
// against a game-rules model driven by its own copy of the LFSR sequence.
module tb_jogo_memoria_param;

    localparam int unsigned NBOT    = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned SHOW_T  = 4;
    localparam int unsigned TMR_LIM = 20;
    localparam int unsigned IW      = 2;
    localparam int unsigned AW      = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            jogar;
    logic            modo;
    logic [NBOT-1:0] botoes;
    logic [NBOT-1:0] leds;
    logic            ganhou;
    logic            perdeu;
    logic            pronto;
    logic            db_timeout;
    logic [3:0]      db_estado;
    logic [AW-1:0]   db_rodada;
    logic [AW-1:0]   db_endereco;
    logic [NBOT-1:0] db_memoria;
    logic [NBOT-1:0] db_jogada;

    int              checks   = 0;
    int              failures = 0;
    int              press_idx;
    logic [15:0]     m_lfsr;
    logic [IW-1:0]   seq [DEPTH];

    jogo_memoria_param #(
        .NBOT(NBOT), .DEPTH(DEPTH), .SHOW_T(SHOW_T), .TMR_LIM(TMR_LIM)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .botoes(botoes),
        .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
        .db_timeout(db_timeout), .db_estado(db_estado), .db_rodada(db_rodada),
        .db_endereco(db_endereco), .db_memoria(db_memoria), .db_jogada(db_jogada)
    );

    always #5 clock = ~clock;

    // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    always @(posedge clock) m_lfsr <= (!reset) ? 16'hACE1 : lfsr_step(m_lfsr);

    function automatic logic [NBOT-1:0] oh(input int v);
        logic [NBOT-1:0] r;
        r = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_estado"}, 32'(db_estado), 32'h0);
        chk({tag, "_leds"}, 32'(leds), 32'h0);
        chk({tag, "_flags"}, 32'({ganhou, perdeu, pronto, db_timeout}), 32'h0);
        chk({tag, "_rodada"}, 32'(db_rodada), 32'h0);
        chk({tag, "_endereco"}, 32'(db_endereco), 32'h0);
        chk({tag, "_memoria"}, 32'(db_memoria), 32'h0);
        chk({tag, "_jogada"}, 32'(db_jogada), 32'h0);
    endtask

    // Pulse jogar for one cycle, then capture the DEPTH LFSR values GERA stores.
    task automatic start_game(input bit m);
        modo  = m;
        jogar = 1'b1;
        tick();
        jogar = 1'b0;
        modo  = ~m;
        for (int k = 0; k < int'(DEPTH); k++) begin
            chk("gera_estado", 32'(db_estado), 32'h1);
            seq[k] = m_lfsr[IW-1:0];
            tick();
        end
        chk("start_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'h0);
        chk("start_jogada", 32'(db_jogada), 32'h0);
    endtask

    // Expect n on/off pairs; jogar is toggled to confirm it is ignored here.
    task automatic show(input int n, input bit hold_end, input logic [NBOT-1:0] hv);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < int'(SHOW_T); c++) begin
                chk("on_estado", 32'(db_estado), 32'h2);
                chk("on_leds", 32'(leds), 32'(oh(int'(seq[i]))));
                jogar = 1'($urandom_range(1, 0));
                tick();
            end
            for (int c = 0; c < int'(SHOW_T); c++) begin
                chk("off_estado", 32'(db_estado), 32'h3);
                chk("off_leds", 32'(leds), 32'h0);
                jogar = 1'($urandom_range(1, 0));
                if (hold_end && i == n - 1 && c == int'(SHOW_T) - 1) botoes = hv;
                tick();
            end
        end
        jogar = 1'b0;
        chk("espera_entry", 32'(db_estado), 32'h4);
        chk("espera_endereco0", 32'(db_endereco), 32'h0);
    endtask

    // Present v on a fresh press, hold through REGISTRA, release in COMPARA.
    task automatic press(input logic [NBOT-1:0] v);
        botoes = v;
        tick();
        chk("registra_estado", 32'(db_estado), 32'h5);
        tick();
        chk("compara_estado", 32'(db_estado), 32'h6);
        chk("jogada", 32'(db_jogada), 32'(v));
        botoes = '0;
        tick();
    endtask

    task automatic play_game(input bit m, input int wrong_pos, input bit multi,
                             input bit hold, input bit late);
        int r;
        int w;
        int b;
        bit done;
        bit hold_pending;
        logic [NBOT-1:0] v;
        logic [NBOT-1:0] want;
        start_game(m);
        r = m ? 0 : int'(DEPTH) - 1;
        press_idx = 0;
        done = 1'b0;
        hold_pending = hold;
        while (!done) begin
            show(r + 1, hold_pending, oh(int'(seq[0])));
            if (hold_pending) begin
                // Button already down on ESPERA entry must not count as a press.
                repeat (3) begin
                    tick();
                    chk("hold_no_press", 32'(db_estado), 32'h4);
                end
                botoes = '0;
                tick();
                chk("hold_release", 32'(db_estado), 32'h4);
                hold_pending = 1'b0;
            end
            for (int p = 0; p <= r; p++) begin
                want = oh(int'(seq[p]));
                w = (late && press_idx == 0) ? int'(TMR_LIM) - 1 : 1 + int'($urandom_range(4, 0));
                for (int i = 0; i < w; i++) begin
                    chk("espera_estado", 32'(db_estado), 32'h4);
                    tick();
                end
                chk("espera_late", 32'(db_estado), 32'h4);
                chk("memoria", 32'(db_memoria), 32'(want));
                chk("endereco", 32'(db_endereco), 32'(p));
                chk("rodada", 32'(db_rodada), 32'(r));
                v = want;
                if (press_idx == wrong_pos) begin
                    if (multi) begin
                        v = 4'b0011;
                    end else begin
                        b = (int'(seq[p]) + 1 + int'($urandom_range(NBOT - 2, 0))) % int'(NBOT);
                        v = oh(b);
                    end
                end
                press(v);
                press_idx++;
                if (v != want) begin
                    chk("erro_estado", 32'(db_estado), 32'hE);
                    chk("erro_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'b0110);
                    repeat (10) begin
                        botoes = NBOT'($urandom);
                        tick();
                        chk("erro_hold", 32'({db_estado, perdeu, leds}), 32'({4'hE, 1'b1, 4'h0}));
                    end
                    botoes = '0;
                    done = 1'b1;
                    break;
                end else if (p < r) begin
                    chk("prox_jogada", 32'(db_estado), 32'h7);
                    tick();
                    chk("volta_espera", 32'(db_estado), 32'h4);
                end else if (r == int'(DEPTH) - 1) begin
                    chk("acertou_estado", 32'(db_estado), 32'hA);
                    chk("acertou_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'b1010);
                    repeat (100) begin
                        botoes = NBOT'($urandom);
                        tick();
                        chk("acertou_hold", 32'({db_estado, ganhou, pronto, leds}), 32'({4'hA, 2'b11, 4'h0}));
                    end
                    botoes = '0;
                    done = 1'b1;
                    break;
                end else begin
                    chk("prox_rodada", 32'(db_estado), 32'h8);
                    tick();
                    r++;
                    break;
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b0;
        jogar  = 1'b0;
        modo   = 1'b0;
        botoes = '0;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b1;
        tick();
        chk_idle("idle");

        // Full sequence win, with one press landing on the last timer cycle.
        play_game(1'b0, -1, 1'b0, 1'b0, 1'b1);
        // Growing sequence win.
        play_game(1'b1, -1, 1'b0, 1'b0, 1'b0);
        // Wrong single button on the first press.
        play_game(1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Timeout: no press for TMR_LIM cycles in ESPERA.
        start_game(1'b0);
        show(int'(DEPTH), 1'b0, '0);
        for (int i = 1; i < int'(TMR_LIM); i++) begin
            tick();
            chk("timeout_wait", 32'({db_estado, perdeu}), 32'({4'h4, 1'b0}));
        end
        tick();
        chk("timeout_estado", 32'(db_estado), 32'hE);
        chk("timeout_flags", 32'({ganhou, perdeu, pronto, db_timeout}), 32'b0111);
        chk("timeout_leds", 32'(leds), 32'h0);

        // Multi-bit press is a loss, and restart clears db_timeout.
        play_game(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Reset during MOSTRA_ON.
        start_game(1'b1);
        chk("pre_rst_estado", 32'(db_estado), 32'h2);
        tick();
        chk("pre_rst_leds", 32'(leds), 32'(oh(int'(seq[0]))));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_idle("rst_mid");
        tick();
        chk_idle("rst_mid_idle");

        // Restart normally, with a button held across the display/ESPERA boundary.
        play_game(1'b0, -1, 1'b0, 1'b1, 1'b0);

        for (int g = 0; g < 4; g++) begin
            bit m;
            int wp;
            m  = 1'($urandom_range(1, 0));
            wp = int'($urandom_range(m ? 10 : 4, 0));
            play_game(m, wp, 1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jogo_memoria_param.md
JOGO_MEMORIA_PARAM -- requirements
Module: jogo_memoria_param

Interface
REQ-001 Parameters (name, default, meaning):
- NBOT, 4, button/LED count; power of two, 2..8; IW = log2(NBOT).
- DEPTH, 16, maximum sequence length, 2..32; AW = clog2(DEPTH).
- SHOW_T, 500, clock cycles each LED is on, and gap length, during display.
- TMR_LIM, 5000, cycles without a press before timeout.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-low.
- jogar, in, 1, start/restart request, level sampled per cycle.
- modo, in, 1, 0 = full sequence each game, 1 = growing sequence; latched on start.
- botoes, in, NBOT, player buttons, active-high.
- leds, out, NBOT, one-hot display of sequence entry, else 0.
- ganhou, out, 1, game won, held.
- perdeu, out, 1, game lost, held.
- pronto, out, 1, ganhou | perdeu.
- db_timeout, out, 1, loss was caused by timeout.
- db_estado, out, 4, current state code.
- db_rodada, out, AW, current round limit index.
- db_endereco, out, AW, current sequence index.
- db_memoria, out, NBOT, one-hot of the entry at db_endereco.
- db_jogada, out, NBOT, last registered press.

Function
REQ-003 States and codes: INICIAL=0, GERA=1, MOSTRA_ON=2, MOSTRA_OFF=3, ESPERA=4, REGISTRA=5, COMPARA=6, PROX_JOGADA=7, PROX_RODADA=8, ACERTOU=A, ERROU=E.
REQ-004 INICIAL or ACERTOU or ERROU with jogar=1 goes to GERA; latch modo; clear ganhou, perdeu, db_timeout and db_jogada.
REQ-005 Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle. GERA writes entry[k]=lfsr[IW-1:0] for k=0..DEPTH-1, one entry per cycle, so GERA lasts exactly DEPTH cycles.
REQ-006 Leaving GERA sets rodada=0 when modo=1 and rodada=DEPTH-1 when modo=0; endereco=0; next state is MOSTRA_ON.
REQ-007 MOSTRA_ON drives leds=onehot(entry[endereco]) for SHOW_T cycles. MOSTRA_OFF then drives leds=0 for SHOW_T cycles.
REQ-008 After MOSTRA_OFF: if endereco<rodada, increment endereco and return to MOSTRA_ON; else set endereco=0, clear the timer and go to ESPERA.
REQ-009 Press detection: a press is the first cycle in ESPERA where botoes!=0 and the registered previous botoes==0. ESPERA then goes to REGISTRA, which stores botoes into db_jogada.
REQ-010 COMPARA outcome:
- db_jogada equal to onehot(entry[endereco]) is a hit; anything else, including multiple bits set, goes to ERROU.
- hit with endereco<rodada goes to PROX_JOGADA: increment endereco, clear timer, go to ESPERA.
- hit with endereco==rodada and rodada==DEPTH-1 goes to ACERTOU.
- otherwise a hit goes to PROX_RODADA: rodada+1, endereco=0, go to MOSTRA_ON.
REQ-011 Timer counts every cycle in ESPERA. When it reaches TMR_LIM-1 with no press, go to ERROU with db_timeout=1. A press on that same cycle takes priority over the timeout.
REQ-012 ACERTOU: ganhou=1. ERROU: perdeu=1. Both hold with leds=0 until jogar or reset.
REQ-013 A button held down across a state change is not a new press; release to all-zero is required first.
REQ-014 jogar is ignored in every state other than those named in REQ-004.
REQ-015 Counters are saturation-free. endereco and rodada never exceed DEPTH-1 by construction.

Reset
REQ-016 reset=0 at a clock edge sets:
- state INICIAL.
- all outputs 0.
- endereco=0, rodada=0, timer=0.
- LFSR=16'hACE1.
- previous-botoes register 0.
Sequence memory contents are don't-care.
REQ-017 Reset mid-game (any state) takes effect at the next edge; no output glitches beyond that edge.

Verification
REQ-018 Directed scenarios (NBOT=4, DEPTH=4, SHOW_T=4, TMR_LIM=20):
- Reset, then jogar=1 for 1 cycle, modo=0: db_estado goes 0->1 for 4 cycles -> 2. Then 4 on/off pairs of 4 cycles each, leds one-hot each, then state 4.
- modo=0: press db_memoria value 4 times, releasing in between -> ganhou=1, pronto=1, db_estado=A, held 100 cycles.
- modo=1: answer correctly each round -> rounds display 1, 2, 3, 4 entries; after the 4th round, ganhou=1.
- modo=0: first press is wrong (~db_memoria & 4'b1111 one bit) -> perdeu=1, db_timeout=0, db_estado=E.
- In ESPERA, no press for 20 cycles -> perdeu=1, db_timeout=1. Then press botoes=4'b0011 in a new game -> perdeu.
- reset=0 during MOSTRA_ON -> next cycle leds=0, db_estado=0. Then jogar restarts normally.
